// File: rtl/poly_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : poly_add_ctrl
//  Description : Adds polynomial vectors one coefficient per cycle. It reads
//                the coefficient memories A and B through a shared read port,
//                registers a + b, and writes the result memory. A start/busy/
//                done handshake controls each operation.
//                Optional macro POLY_ADD_CTRL_MOD_REDUCE_EN reduces each sum
//                modulo Q. Both inputs must then lie in [0,Q).
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_add_ctrl #(
  parameter int K      = 4,
  parameter int N      = 256,
  parameter int Q      = 8380417,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        num_polys,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data_a,
  input  logic [31:0]       rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data
);

  // Stop elaboration when the parameters cannot address the whole vector.
  if ((K < 1) || (K > 8) || (N < 1) || (Q < 2) || ((2 ** ADDR_W) < (K * N))) begin : g_param_err
    $error("poly_add_ctrl: illegal parameter combination");
  end

  localparam logic [3:0]        K_W   = 4'(K);
  localparam logic [ADDR_W+3:0] N_W   = (ADDR_W + 4)'(N);
  localparam logic [ADDR_W+3:0] ONE_W = (ADDR_W + 4)'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] last_addr;       // TOTAL-1 for the running operation
  logic              p1_valid;        // read data from the memories is valid this cycle
  logic [ADDR_W-1:0] p1_addr;         // address that matches rd_data_a/b
  logic [3:0]        m_clamped;
  logic [ADDR_W+3:0] total_next;
  logic [ADDR_W-1:0] last_addr_next;
  logic [31:0]       sum_next;

  // A polynomial count of 0, or one above K, selects all K polynomials.
  always_comb begin
    m_clamped = num_polys;
    if ((num_polys == 4'd0) || (num_polys > K_W)) begin
      m_clamped = K_W;
    end
    total_next     = {{ADDR_W{1'b0}}, m_clamped} * N_W;
    last_addr_next = ADDR_W'(total_next - ONE_W);
  end

`ifdef POLY_ADD_CTRL_MOD_REDUCE_EN
  localparam logic [32:0] Q_W = 33'(Q);
  logic [32:0] sum_wide;

  // With both inputs in [0,Q), one conditional subtraction brings the sum back into [0,Q).
  always_comb begin
    sum_wide = {1'b0, rd_data_a} + {1'b0, rd_data_b};
    sum_next = sum_wide[31:0];
    if (sum_wide >= Q_W) begin
      sum_next = 32'(sum_wide - Q_W);
    end
  end
`else
  // Plain two's-complement add that wraps. The carry out is discarded.
  always_comb begin
    sum_next = rd_data_a + rd_data_b;
  end
`endif

  // Control FSM: accept start, issue consecutive reads, wait for the pipeline to drain, pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      last_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ISSUE;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            last_addr <= last_addr_next;
          end
        end
        ST_ISSUE: begin
          if (rd_addr == last_addr) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          // The last read data is consumed when p1_valid drops, and its write is on the port now.
          if (!p1_valid) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath: align the address with the memory latency, register the sum, and hold the write port while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_addr  <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      p1_valid <= rd_en;
      p1_addr  <= rd_addr;
      wr_en    <= p1_valid;
      if (p1_valid) begin
        wr_addr <= p1_addr;
        wr_data <= sum_next;
      end
    end
  end

endmodule
`default_nettype wire
